// File: rtl/spine_out_arbiter_pkg.sv
// Shared router definitions: requester indices, flit fields,
// and the output arbiter state encoding.
package router_defs;

  localparam int NREQ      = 5;
  localparam int DWIDTH    = 16;
  localparam int CREDITS   = 4;

  localparam int PORT_GPU  = 0;
  localparam int PORT_SP12 = 1;
  localparam int PORT_SP22 = 2;
  localparam int PORT_SP32 = 3;
  localparam int PORT_SP42 = 4;

  localparam int DEST_MSB  = DWIDTH - 1;
  localparam int DEST_LSB  = DWIDTH - 6;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/spine_out_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or
// after ptr_i, wrapping NREQ-1 -> 0 for any NREQ.
module rr_pick #(
  parameter int NREQ = 5,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  int c;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    c        = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = (int'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[c]) begin
        any_o       = 1'b1;
        idx_o       = PW'(c);
        onehot_o[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spine_out_arbiter.sv
// Packet-level round-robin output arbiter with downstream
// credit flow control; grant is held until the packet tail.
module spine_out_arbiter #(
  parameter int NREQ    = router_defs::NREQ,
  parameter int DWIDTH  = router_defs::DWIDTH,
  parameter int CREDITS = router_defs::CREDITS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         arb_enable,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0]              req_last,
  input  logic [NREQ*DWIDTH-1:0]       req_data,
  output logic [NREQ-1:0]              req_ready,
  input  logic                         credit_return,
  output logic [DWIDTH-1:0]            out_data,
  output logic                         out_valid,
  output logic [NREQ-1:0]              grant,
  output logic                         busy,
  output logic [$clog2(CREDITS+1)-1:0] credit_count,
  output logic                         err_credit_ovf
);

  import router_defs::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(CREDITS + 1);

  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cred_q, cred_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              ovld_q, ovld_d;
  logic              err_q, err_d;

  logic [NREQ-1:0]   pick_oh;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic              has_cred;
  logic              xfer;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign has_cred = (cred_q != '0);
  assign xfer     = (state_q == ARB_LOCKED)
                 && req_valid[owner_q] && has_cred;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cred_d    = cred_q;
    data_d    = data_q;
    ovld_d    = 1'b0;
    err_d     = err_q;
    req_ready = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (arb_enable && pick_any && has_cred) begin
          state_d = ARB_LOCKED;
          grant_d = pick_oh;
          owner_d = pick_idx;
        end
      end
      ARB_LOCKED: begin
        if (xfer) begin
          req_ready[owner_q] = 1'b1;
          data_d = req_data[int'(owner_q)*DWIDTH +: DWIDTH];
          ovld_d = 1'b1;
          if (req_last[owner_q]) begin
            state_d = ARB_IDLE;
            grant_d = '0;
            ptr_d   = (owner_q == PW'(NREQ - 1))
                    ? '0 : owner_q + PW'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // Return and transfer in the same cycle cancel out.
    unique case ({credit_return, xfer})
      2'b10: begin
        if (cred_q == CW'(CREDITS)) err_d = 1'b1;
        else cred_d = cred_q + CW'(1);
      end
      2'b01:   cred_d = cred_q - CW'(1);
      default: cred_d = cred_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cred_q  <= CW'(CREDITS);
      data_q  <= '0;
      ovld_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cred_q  <= cred_d;
      data_q  <= data_d;
      ovld_q  <= ovld_d;
      err_q   <= err_d;
    end
  end

  assign grant          = grant_q;
  assign busy           = (state_q == ARB_LOCKED);
  assign credit_count   = cred_q;
  assign out_data       = data_q;
  assign out_valid      = ovld_q;
  assign err_credit_ovf = err_q;

endmodule

// File: tb/tb_spine_out_arbiter.sv
// Directed self-checking bench for spine_out_arbiter.
// Inputs change 1 time unit after a rising edge; checks follow.
module tb_spine_out_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        arb_enable;
  logic [4:0]  req_valid;
  logic [4:0]  req_last;
  logic [79:0] req_data;
  logic [4:0]  req_ready;
  logic        credit_return;
  logic [15:0] out_data;
  logic        out_valid;
  logic [4:0]  grant;
  logic        busy;
  logic [2:0]  credit_count;
  logic        err_credit_ovf;

  int total = 0;
  int bad   = 0;

  spine_out_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .arb_enable     (arb_enable),
    .req_valid      (req_valid),
    .req_last       (req_last),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .credit_return  (credit_return),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .grant          (grant),
    .busy           (busy),
    .credit_count   (credit_count),
    .err_credit_ovf (err_credit_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    arb_enable = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    credit_return = 1'b0;
    step();
    step();
    reset = 1'b0;
    total++;
    if (credit_count !== 3'd4) begin
      bad++;
      $display("FAIL reset_cred got=%0d exp=4", credit_count);
    end
    total++;
    if (grant !== 5'b0) begin
      bad++;
      $display("FAIL reset_grant got=%b exp=0", grant);
    end
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_vb got=%b%b exp=00", out_valid, busy);
    end
    total++;
    if (err_credit_ovf !== 1'b0 || out_data !== 16'h0) begin
      bad++;
      $display("FAIL reset_err got=%b/%h exp=0/0000",
               err_credit_ovf, out_data);
    end
  endtask

  task automatic test_packet();
    logic [15:0] flits [3];
    flits[0] = 16'h1111;
    flits[1] = 16'h2222;
    flits[2] = 16'h3333;
    req_valid = 5'b00010;
    req_data[16 +: 16] = flits[0];
    step();
    total++;
    if (grant !== 5'b00010 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pkt_grant got=%b exp=00010", grant);
    end
    for (int i = 0; i < 3; i++) begin
      req_data[16 +: 16] = flits[i];
      req_last[1] = (i == 2);
      credit_return = 1'b1;
      total++;
      if (req_ready !== 5'b00010) begin
        bad++;
        $display("FAIL pkt_ready%0d got=%b exp=00010", i, req_ready);
      end
      step();
      total++;
      if (out_valid !== 1'b1 || out_data !== flits[i]) begin
        bad++;
        $display("FAIL pkt_data%0d got=%b/%h exp=1/%h",
                 i, out_valid, out_data, flits[i]);
      end
    end
    credit_return = 1'b0;
    req_last = '0;
    total++;
    if (grant !== 5'b0 || busy !== 1'b0 || credit_count !== 3'd4) begin
      bad++;
      $display("FAIL pkt_end got=%b/%b/%0d exp=0/0/4",
               grant, busy, credit_count);
    end
    req_valid = 5'b00011;
    req_last = 5'b00011;
    step();
    total++;
    if (grant !== 5'b00001) begin
      bad++;
      $display("FAIL pkt_rrptr got=%b exp=00001", grant);
    end
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    req_valid = '0;
    req_last = '0;
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_oh;
    test_reset();
    req_valid = 5'b11111;
    req_last = 5'b11111;
    for (int i = 0; i < 5; i++) req_data[i*16 +: 16] = 16'hA000 + 16'(i);
    for (int k = 0; k < 6; k++) begin
      exp_oh = 5'b00001 << (k % 5);
      step();
      total++;
      if (grant !== exp_oh || req_ready !== exp_oh) begin
        bad++;
        $display("FAIL rr_grant%0d got=%b/%b exp=%b",
                 k, grant, req_ready, exp_oh);
      end
      credit_return = 1'b1;
      step();
      credit_return = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'hA000 + 16'(k % 5)
          || grant !== 5'b0) begin
        bad++;
        $display("FAIL rr_flit%0d got=%b/%h/%b exp=1/%h/00000",
                 k, out_valid, out_data, grant, 16'hA000 + 16'(k % 5));
      end
    end
    req_valid = '0;
    req_last = '0;
  endtask

  task automatic test_credit_stall();
    int moved;
    test_reset();
    req_valid = 5'b00001;
    req_data[0 +: 16] = 16'h4000;
    step();
    moved = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) moved++;
    end
    total++;
    if (moved !== 4 || credit_count !== 3'd0) begin
      bad++;
      $display("FAIL stall_moved got=%0d/%0d exp=4/0", moved, credit_count);
    end
    total++;
    if (req_ready !== 5'b0 || grant !== 5'b00001 || busy !== 1'b1) begin
      bad++;
      $display("FAIL stall_hold got=%b/%b exp=00000/00001",
               req_ready, grant);
    end
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    moved = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid) moved++;
    end
    total++;
    if (moved !== 1 || credit_count !== 3'd0 || grant !== 5'b00001) begin
      bad++;
      $display("FAIL stall_one got=%0d/%0d/%b exp=1/0/00001",
               moved, credit_count, grant);
    end
    req_valid = '0;
  endtask

  task automatic test_credit_edges();
    test_reset();
    req_valid = 5'b00001;
    step();
    step();
    step();
    total++;
    if (credit_count !== 3'd2) begin
      bad++;
      $display("FAIL edge_two got=%0d exp=2", credit_count);
    end
    credit_return = 1'b1;
    step();
    total++;
    if (credit_count !== 3'd2 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL edge_same got=%0d/%b exp=2/1", credit_count, out_valid);
    end
    req_last = 5'b00001;
    step();
    req_valid = '0;
    req_last = '0;
    step();
    step();
    total++;
    if (credit_count !== 3'd4 || err_credit_ovf !== 1'b0) begin
      bad++;
      $display("FAIL edge_full got=%0d/%b exp=4/0",
               credit_count, err_credit_ovf);
    end
    step();
    credit_return = 1'b0;
    total++;
    if (credit_count !== 3'd4 || err_credit_ovf !== 1'b1) begin
      bad++;
      $display("FAIL edge_ovf got=%0d/%b exp=4/1",
               credit_count, err_credit_ovf);
    end
    step();
    step();
    total++;
    if (err_credit_ovf !== 1'b1) begin
      bad++;
      $display("FAIL edge_sticky got=%b exp=1", err_credit_ovf);
    end
  endtask

  task automatic test_enable_and_reset();
    test_reset();
    req_valid = 5'b00100;
    req_data[32 +: 16] = 16'hC000;
    req_data[48 +: 16] = 16'hD000;
    step();
    arb_enable = 1'b0;
    req_valid = 5'b01100;
    credit_return = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_data[32 +: 16] = 16'hC000 + 16'(i);
      req_last[2] = (i == 2);
      total++;
      if (grant !== 5'b00100) begin
        bad++;
        $display("FAIL en_hold%0d got=%b exp=00100", i, grant);
      end
      step();
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'hC000 + 16'(i)) begin
        bad++;
        $display("FAIL en_flit%0d got=%b/%h exp=1/%h",
                 i, out_valid, out_data, 16'hC000 + 16'(i));
      end
    end
    credit_return = 1'b0;
    req_last = '0;
    req_valid = 5'b01000;
    step();
    step();
    total++;
    if (grant !== 5'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL en_block got=%b/%b exp=00000/0", grant, busy);
    end
    arb_enable = 1'b1;
    step();
    total++;
    if (grant !== 5'b01000) begin
      bad++;
      $display("FAIL en_grant got=%b exp=01000", grant);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'hD000) begin
      bad++;
      $display("FAIL mid_flit got=%b/%h exp=1/d000", out_valid, out_data);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_valid = '0;
    total++;
    if (out_valid !== 1'b0 || grant !== 5'b0 || busy !== 1'b0
        || credit_count !== 3'd4 || out_data !== 16'h0) begin
      bad++;
      $display("FAIL mid_reset got=%b/%b/%b/%0d/%h exp=0/00000/0/4/0000",
               out_valid, grant, busy, credit_count, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_round_robin();
    test_credit_stall();
    test_credit_edges();
    test_enable_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
